// File: rtl/lfsr_pkg.sv
// lfsr_pkg
// Shared definitions for the 8-bit XNOR Fibonacci LFSR generator/checker pair:
//   - lfsr8_next   : next-state function (taps 8,6,5,4; XNOR feedback)
//   - LFSR8_LOCKUP : the all-ones state that maps onto itself
//   - chk_state_t  : checker FSM states
package lfsr_pkg;

  localparam logic [7:0] LFSR8_LOCKUP = 8'hFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // XNOR feedback shifted into bit 0; only the all-ones state maps onto itself.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side checker for the 8-bit XNOR LFSR link. Hunts for a seed,
// verifies LOCK_COUNT consecutive consistent words, then flywheels its own
// expected state and flags every deviating word.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   in_valid   in   in_data carries a generator word this cycle
//   in_data    in   received LFSR state (8 bits)
//   locked     out  checker is in LOCKED
//   err        out  one-cycle pulse: last accepted word mismatched while locked
//   err_count  out  saturating count of locked-state mismatches (ERR_W bits)
//   expected   out  word the checker expects on the next valid cycle
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       expected
);

  // The counters never store their terminal value: the transition fires when
  // the stored count is one short of it, so $clog2 of the parameter suffices.
  localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MISS_W  = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_COUNT - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};

  chk_state_t         state_r;
  logic [MATCH_W-1:0] match_cnt_r;
  logic [MISS_W-1:0]  miss_cnt_r;
  logic               locked_r;
  logic               err_r;
  logic [ERR_W-1:0]   err_count_r;
  logic [7:0]         expected_r;

  logic               hit_s;
  logic               seed_ok_s;

  // Word classification against the current expectation.
  always_comb begin
    hit_s     = (in_data == expected_r);
    seed_ok_s = (in_data != LFSR8_LOCKUP);
  end

  // Checker FSM with its match/miss/error counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= HUNT;
      match_cnt_r <= '0;
      miss_cnt_r  <= '0;
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= '0;
      expected_r  <= 8'h00;
    end else begin
      err_r <= 1'b0;
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            if (seed_ok_s) begin
              expected_r  <= lfsr8_next(in_data);
              match_cnt_r <= MATCH_W'(1);
              state_r     <= VERIFY;
            end else begin
              state_r <= HUNT;
            end
          end

          VERIFY: begin
            if (hit_s) begin
              expected_r <= lfsr8_next(expected_r);
              if (match_cnt_r == MATCH_LAST) begin
                state_r     <= LOCKED;
                locked_r    <= 1'b1;
                miss_cnt_r  <= '0;
                match_cnt_r <= '0;
              end else begin
                match_cnt_r <= match_cnt_r + MATCH_W'(1);
              end
            end else if (seed_ok_s) begin
              // Restart the run from the word just received.
              expected_r  <= lfsr8_next(in_data);
              match_cnt_r <= MATCH_W'(1);
            end else begin
              match_cnt_r <= '0;
              state_r     <= HUNT;
            end
          end

          LOCKED: begin
            // Flywheel: advance whether or not the word matched.
            expected_r <= lfsr8_next(expected_r);
            if (hit_s) begin
              miss_cnt_r <= '0;
            end else begin
              err_r <= 1'b1;
              if (err_count_r != ERR_MAX) begin
                err_count_r <= err_count_r + ERR_W'(1);
              end else begin
                err_count_r <= err_count_r;
              end
              if (miss_cnt_r == MISS_LAST) begin
                miss_cnt_r <= '0;
                locked_r   <= 1'b0;
                state_r    <= HUNT;
              end else begin
                miss_cnt_r <= miss_cnt_r + MISS_W'(1);
              end
            end
          end

          default: begin
            state_r     <= HUNT;
            locked_r    <= 1'b0;
            match_cnt_r <= '0;
            miss_cnt_r  <= '0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign locked    = locked_r;
  assign err       = err_r;
  assign err_count = err_count_r;
  assign expected  = expected_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
// Self-checking bench for lfsr_checker: directed scenarios plus a randomized
// stream compared against a behavioural model built on the history of
// received words (lock = last LOCK_COUNT words form a valid LFSR chain).
module tb_lfsr_checker;

  localparam int LC = 4;
  localparam int UC = 3;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          locked;
  logic          err;
  logic [EW-1:0] err_count;
  logic [7:0]    expected;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit            m_locked;
  bit            m_err;
  logic [EW-1:0] m_cnt;
  logic [7:0]    m_exp;
  int            m_miss;
  logic [7:0]    hist[$];

  lfsr_checker #(.LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err(err), .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] nxt(input logic [7:0] s);
    logic fb;
    fb = ~(s[7] ^ s[5] ^ s[4] ^ s[3]);
    return {s[6:0], fb};
  endfunction

  // True when the newest LC received words form a chain from a non-FF seed.
  function automatic bit tail_is_chain();
    int n;
    n = hist.size();
    if (n < LC) return 1'b0;
    if (hist[n-LC] == 8'hFF) return 1'b0;
    for (int i = n - LC; i < n - 1; i++)
      if (hist[i+1] != nxt(hist[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_locked = 1'b0; m_err = 1'b0; m_cnt = '0; m_exp = 8'h00; m_miss = 0;
    hist.delete();
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d);
    m_err = 1'b0;
    if (!v) return;
    if (!m_locked) begin
      hist.push_back(d);
      if (hist.size() > LC) void'(hist.pop_front());
      if (d != 8'hFF) m_exp = nxt(d);
      if (tail_is_chain()) begin
        m_locked = 1'b1; m_miss = 0; hist.delete();
      end
    end else begin
      m_err = (d != m_exp);
      m_exp = nxt(m_exp);
      if (m_err) begin
        if (m_cnt != {EW{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_miss++;
        if (m_miss == UC) begin
          m_locked = 1'b0; m_miss = 0; hist.delete();
        end
      end else begin
        m_miss = 0;
      end
    end
  endfunction

  // One clock: drive on negedge, let the edge sample, settle past it.
  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    model_step(v, d);
  endtask

  // Reset with in_valid asserted to show reset wins.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    if (err_count !== '0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", err_count); end
    if (expected !== 8'h00) begin failures++; $display("FAIL reset_expected got=%h want=00", expected); end
  endtask

  task automatic test_lock();
    logic [7:0] words[4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i]);
      checks++;
      if (locked !== (i == 3)) begin failures++; $display("FAIL lock_locked[%0d] got=%b want=%b", i, locked, (i == 3)); end
    end
    checks += 2;
    if (expected !== 8'h1E) begin failures++; $display("FAIL lock_expected got=%h want=1e", expected); end
    if (err_count !== '0) begin failures++; $display("FAIL lock_cnt got=%0d want=0", err_count); end
  endtask

  task automatic test_single_error();
    step(1'b1, 8'h1E);
    step(1'b1, 8'h55);
    checks += 3;
    if (err !== 1'b1) begin failures++; $display("FAIL single_err_pulse got=%b want=1", err); end
    if (err_count !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d want=1", err_count); end
    if (locked !== 1'b1) begin failures++; $display("FAIL single_locked got=%b want=1", locked); end
    step(1'b1, 8'h7A);
    checks += 3;
    if (err !== 1'b0) begin failures++; $display("FAIL single_err_clear got=%b want=0", err); end
    if (expected !== 8'hF4) begin failures++; $display("FAIL single_expected got=%h want=f4", expected); end
    if (locked !== 1'b1) begin failures++; $display("FAIL single_locked2 got=%b want=1", locked); end
  endtask

  task automatic test_unlock();
    logic [EW-1:0] base;
    base = err_count;
    for (int i = 0; i < UC; i++) begin
      step(1'b1, m_exp ^ 8'h01);
      checks += 3;
      if (err !== 1'b1) begin failures++; $display("FAIL unlock_err[%0d] got=%b want=1", i, err); end
      if (err_count !== base + EW'(i + 1)) begin failures++; $display("FAIL unlock_cnt[%0d] got=%0d want=%0d", i, err_count, base + EW'(i + 1)); end
      if (locked !== (i != UC - 1)) begin failures++; $display("FAIL unlock_locked[%0d] got=%b want=%b", i, locked, (i != UC - 1)); end
    end
    // Back in HUNT: a mismatch now must not pulse err or count.
    step(1'b1, 8'h33);
    checks += 2;
    if (err !== 1'b0) begin failures++; $display("FAIL unlock_hunt_err got=%b want=0", err); end
    if (err_count !== base + EW'(UC)) begin failures++; $display("FAIL unlock_hunt_cnt got=%0d want=%0d", err_count, base + EW'(UC)); end
  endtask

  task automatic test_lockup();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'hFF);
      checks += 3;
      if (locked !== 1'b0) begin failures++; $display("FAIL lockup_locked[%0d] got=%b want=0", i, locked); end
      if (err !== 1'b0) begin failures++; $display("FAIL lockup_err[%0d] got=%b want=0", i, err); end
      if (expected !== 8'h00) begin failures++; $display("FAIL lockup_expected[%0d] got=%h want=00", i, expected); end
    end
    test_lock();
  endtask

  task automatic test_verify_restart();
    logic [7:0] w;
    do_reset();
    step(1'b1, 8'h01);
    step(1'b1, 8'h03);
    w = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w);
      checks++;
      if (locked !== (i == 3)) begin failures++; $display("FAIL restart_locked[%0d] got=%b want=%b", i, locked, (i == 3)); end
      w = nxt(w);
    end
    checks += 2;
    if (err_count !== '0) begin failures++; $display("FAIL restart_cnt got=%0d want=0", err_count); end
    if (expected !== w) begin failures++; $display("FAIL restart_expected got=%h want=%h", expected, w); end
  endtask

  task automatic test_gaps_reset();
    do_reset();
    step(1'b1, 8'h01);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h5A);
      checks += 2;
      if (expected !== 8'h03) begin failures++; $display("FAIL gap_expected[%0d] got=%h want=03", i, expected); end
      if (locked !== 1'b0) begin failures++; $display("FAIL gap_locked[%0d] got=%b want=0", i, locked); end
    end
    step(1'b1, 8'h03);
    step(1'b1, 8'h07);
    step(1'b1, 8'h0F);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL gap_lock got=%b want=1", locked); end
    step(1'b1, 8'h00);  // wrong against 1E: one counted error
    checks++;
    if (err_count !== 16'd1) begin failures++; $display("FAIL gap_cnt got=%0d want=1", err_count); end
    do_reset();
    checks += 2;
    if (locked !== 1'b0) begin failures++; $display("FAIL gap_reset_locked got=%b want=0", locked); end
    if (err_count !== '0) begin failures++; $display("FAIL gap_reset_cnt got=%0d want=0", err_count); end
  endtask

  task automatic test_random();
    logic [7:0] g;
    logic [7:0] d;
    bit         v;
    int         r;
    do_reset();
    g = 8'h5C;
    for (int c = 0; c < 1500; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 255);
      if (v) begin
        r = $urandom_range(0, 99);
        if (r < 3) begin
          g = $urandom_range(0, 254);
          d = g;
        end else if (r < 9) begin
          d = g ^ 8'($urandom_range(1, 255));
        end else if (r < 11) begin
          d = 8'hFF;
        end else begin
          d = g;
        end
        g = nxt(g);
      end
      step(v, d);
      checks += 4;
      if (locked !== m_locked) begin failures++; $display("FAIL rand_locked[%0d] got=%b want=%b", c, locked, m_locked); end
      if (err !== m_err) begin failures++; $display("FAIL rand_err[%0d] got=%b want=%b", c, err, m_err); end
      if (err_count !== m_cnt) begin failures++; $display("FAIL rand_cnt[%0d] got=%0d want=%0d", c, err_count, m_cnt); end
      if (expected !== m_exp) begin failures++; $display("FAIL rand_expected[%0d] got=%h want=%h", c, expected, m_exp); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    model_reset();
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_lockup();
    test_verify_restart();
    test_gaps_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
